// File: rtl/drive_arbiter.sv
`default_nettype none
// ============================================================================
// drive_arbiter : shares one H-bridge between line follower, servo and e-stop
// Rev 1.0 - initial release
// ============================================================================
module drive_arbiter #(
  parameter int DEAD_CYCLES = 100000,
  parameter int RAMP_STEP   = 250,
  parameter int RAMP_DIV    = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  follow_dir,
  input  logic [11:0] follow_duty_a,
  input  logic [11:0] follow_duty_b,
  input  logic        servo_req,
  output logic        servo_grant,
  input  logic        estop,
  output logic [3:0]  Direction,
  output logic [11:0] DutyA,
  output logic [11:0] DutyB,
  output logic [2:0]  arb_state
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    RAMP_DOWN = 3'd1,
    DEAD      = 3'd2,
    HOLD      = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [RW-1:0] c_ramp_last = RW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] c_dead_last = DW'(DEAD_CYCLES - 1);
  // A step wider than the duty range simply lands on the target.
  localparam logic [11:0]   c_step      = (RAMP_STEP > 4095) ? 12'd4095 : 12'(RAMP_STEP);

  state_t        state_q, state_d;
  logic [3:0]    dir_q, dir_d;
  logic [11:0]   duty_a_q, duty_a_d;
  logic [11:0]   duty_b_q, duty_b_d;
  logic          grant_q, grant_d;
  logic          flag_q, flag_d;
  logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [DW-1:0] dead_cnt_q, dead_cnt_d;

  logic          w_tick;
  logic [11:0]   w_tgt_a, w_tgt_b;
  logic [11:0]   w_ramp_a, w_ramp_b;
  logic          w_duties_zero;

  function automatic logic [11:0] ramp_to(input logic [11:0] cur, input logic [11:0] tgt);
    logic [11:0] diff;
    if (cur < tgt) begin
      diff    = tgt - cur;
      ramp_to = (diff > c_step) ? cur + c_step : tgt;
    end else begin
      diff    = cur - tgt;
      ramp_to = (diff > c_step) ? cur - c_step : tgt;
    end
  endfunction

  assign w_tick        = (ramp_cnt_q == c_ramp_last);
  assign w_duties_zero = (duty_a_q == 12'd0) && (duty_b_q == 12'd0);

  // Duties only chase the follower while it agrees with the live direction.
  always_comb begin
    w_tgt_a = 12'd0;
    w_tgt_b = 12'd0;
    if (state_q == RUN && !servo_req && follow_dir != 4'd0 && follow_dir == dir_q) begin
      w_tgt_a = follow_duty_a;
      w_tgt_b = follow_duty_b;
    end
  end

  assign w_ramp_a = w_tick ? ramp_to(duty_a_q, w_tgt_a) : duty_a_q;
  assign w_ramp_b = w_tick ? ramp_to(duty_b_q, w_tgt_b) : duty_b_q;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    duty_a_d   = 12'd0;
    duty_b_d   = 12'd0;
    grant_d    = 1'b0;
    flag_d     = 1'b0;
    dead_cnt_d = '0;
    ramp_cnt_d = w_tick ? '0 : ramp_cnt_q + RW'(1);

    case (state_q)
      RUN: begin
        duty_a_d = w_ramp_a;
        duty_b_d = w_ramp_b;
        if (servo_req) begin
          state_d = RAMP_DOWN;
          flag_d  = 1'b1;
        end else if (follow_dir == 4'd0) begin
          if (w_duties_zero) dir_d = 4'd0;
        end else if (dir_q == 4'd0) begin
          dir_d = follow_dir;
        end else if (follow_dir != dir_q) begin
          state_d = RAMP_DOWN;
        end
      end

      RAMP_DOWN: begin
        duty_a_d = w_ramp_a;
        duty_b_d = w_ramp_b;
        flag_d   = flag_q & servo_req;
        if (!flag_d && follow_dir == dir_q) begin
          state_d = RUN;
        end else if (w_ramp_a == 12'd0 && w_ramp_b == 12'd0) begin
          dir_d   = 4'd0;
          state_d = flag_d ? HOLD : DEAD;
        end
      end

      DEAD: begin
        dir_d      = 4'd0;
        dead_cnt_d = dead_cnt_q + DW'(1);
        // Loading the new direction on the exit edge keeps the zero gap exact.
        if (dead_cnt_q == c_dead_last) begin
          state_d    = RUN;
          dead_cnt_d = '0;
          if (!servo_req) dir_d = follow_dir;
        end
      end

      HOLD: begin
        dir_d   = 4'd0;
        grant_d = servo_req;
        flag_d  = servo_req;
        if (!servo_req) state_d = DEAD;
      end

      FAULT: begin
        dir_d = 4'd0;
        if (!estop) state_d = DEAD;
      end

      default: begin
        dir_d   = 4'd0;
        state_d = DEAD;
      end
    endcase

    if (estop) begin
      state_d    = FAULT;
      dir_d      = 4'd0;
      duty_a_d   = 12'd0;
      duty_b_d   = 12'd0;
      grant_d    = 1'b0;
      flag_d     = 1'b0;
      dead_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      dir_q      <= 4'd0;
      duty_a_q   <= 12'd0;
      duty_b_q   <= 12'd0;
      grant_q    <= 1'b0;
      flag_q     <= 1'b0;
      ramp_cnt_q <= '0;
      dead_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      duty_a_q   <= duty_a_d;
      duty_b_q   <= duty_b_d;
      grant_q    <= grant_d;
      flag_q     <= flag_d;
      ramp_cnt_q <= ramp_cnt_d;
      dead_cnt_q <= dead_cnt_d;
    end
  end

  assign Direction   = dir_q;
  assign DutyA       = duty_a_q;
  assign DutyB       = duty_b_q;
  assign servo_grant = grant_q;
  assign arb_state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_drive_arbiter.sv
`default_nettype none
// ============================================================================
// tb_drive_arbiter : directed scoreboard bench for drive_arbiter
// Rev 1.0 - initial release
// ============================================================================
module tb_drive_arbiter;

  localparam logic [2:0] S_RUN  = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_DEAD = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_FLT  = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  follow_dir;
  logic [11:0] follow_duty_a;
  logic [11:0] follow_duty_b;
  logic        servo_req;
  logic        servo_grant;
  logic        estop;
  logic [3:0]  Direction;
  logic [11:0] DutyA;
  logic [11:0] DutyB;
  logic [2:0]  arb_state;

  always #5 clk = ~clk;

  drive_arbiter #(
    .DEAD_CYCLES (4),
    .RAMP_STEP   (1000),
    .RAMP_DIV    (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .follow_dir    (follow_dir),
    .follow_duty_a (follow_duty_a),
    .follow_duty_b (follow_duty_b),
    .servo_req     (servo_req),
    .servo_grant   (servo_grant),
    .estop         (estop),
    .Direction     (Direction),
    .DutyA         (DutyA),
    .DutyB         (DutyB),
    .arb_state     (arb_state)
  );

  typedef struct packed {
    logic [3:0]  dir;
    logic [11:0] a;
    logic [11:0] b;
    logic        g;
    logic [2:0]  st;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   edge_no = 0;

  // One clock edge: queue the expectation, let the edge happen, compare mid-cycle.
  task automatic chk(input logic [3:0] d, input int a, input int b,
                     input logic g, input logic [2:0] st);
    exp_t e;
    exp_t obs;
    e.dir = d;
    e.a   = 12'(a);
    e.b   = 12'(b);
    e.g   = g;
    e.st  = st;
    sb_q.push_back(e);
    @(posedge clk);
    edge_no++;
    @(negedge clk);
    e       = sb_q.pop_front();
    obs.dir = Direction;
    obs.a   = DutyA;
    obs.b   = DutyB;
    obs.g   = servo_grant;
    obs.st  = arb_state;
    n_total++;
    assert (obs === e) n_pass++;
    else $error("FAIL edge%0d observed dir=%h a=%0d b=%0d g=%b st=%0d required dir=%h a=%0d b=%0d g=%b st=%0d",
                edge_no, obs.dir, obs.a, obs.b, obs.g, obs.st, e.dir, e.a, e.b, e.g, e.st);
  endtask

  task automatic chkn(input int n, input logic [3:0] d, input int a, input int b,
                      input logic g, input logic [2:0] st);
    for (int i = 0; i < n; i++) chk(d, a, b, g, st);
  endtask

  initial begin
    rst_n         = 1'b0;
    follow_dir    = 4'h6;
    follow_duty_a = 12'd4000;
    follow_duty_b = 12'd2500;
    servo_req     = 1'b0;
    estop         = 1'b0;

    // reset dominates live follower inputs
    chkn(2, 4'h0, 0, 0, 1'b0, S_RUN);
    edge_no = 0;
    rst_n = 1'b1;

    // direction loads first, then ramp; channel B clamps at 2500
    chk (4'h6, 0, 0, 1'b0, S_RUN);
    chkn(2, 4'h6, 1000, 1000, 1'b0, S_RUN);
    chkn(2, 4'h6, 2000, 2000, 1'b0, S_RUN);
    chkn(2, 4'h6, 3000, 2500, 1'b0, S_RUN);
    chk (4'h6, 4000, 2500, 1'b0, S_RUN);

    // reversal request aborted at 2000: no dead gap
    follow_dir = 4'h9;
    chk (4'h6, 4000, 2500, 1'b0, S_RD);
    chkn(2, 4'h6, 3000, 1500, 1'b0, S_RD);
    chk (4'h6, 2000, 500, 1'b0, S_RD);
    follow_dir = 4'h6;
    chk (4'h6, 2000, 500, 1'b0, S_RUN);
    chkn(2, 4'h6, 3000, 1500, 1'b0, S_RUN);
    chk (4'h6, 4000, 2500, 1'b0, S_RUN);

    // full reversal: ramp down, exactly 4 cycles of zero direction, ramp up
    follow_dir = 4'h9;
    chk (4'h6, 4000, 2500, 1'b0, S_RD);
    chkn(2, 4'h6, 3000, 1500, 1'b0, S_RD);
    chkn(2, 4'h6, 2000, 500, 1'b0, S_RD);
    chkn(2, 4'h6, 1000, 0, 1'b0, S_RD);
    chkn(4, 4'h0, 0, 0, 1'b0, S_DEAD);
    chkn(2, 4'h9, 0, 0, 1'b0, S_RUN);
    chkn(2, 4'h9, 1000, 1000, 1'b0, S_RUN);
    chkn(2, 4'h9, 2000, 2000, 1'b0, S_RUN);
    chkn(2, 4'h9, 3000, 2500, 1'b0, S_RUN);
    chk (4'h9, 4000, 2500, 1'b0, S_RUN);

    // servo handshake: grant one cycle after stop, held, then dead gap
    servo_req = 1'b1;
    chk (4'h9, 4000, 2500, 1'b0, S_RD);
    chkn(2, 4'h9, 3000, 1500, 1'b0, S_RD);
    chkn(2, 4'h9, 2000, 500, 1'b0, S_RD);
    chkn(2, 4'h9, 1000, 0, 1'b0, S_RD);
    chk (4'h0, 0, 0, 1'b0, S_HOLD);
    chkn(3, 4'h0, 0, 0, 1'b1, S_HOLD);
    servo_req = 1'b0;
    chkn(4, 4'h0, 0, 0, 1'b0, S_DEAD);
    chkn(2, 4'h9, 0, 0, 1'b0, S_RUN);
    chkn(2, 4'h9, 1000, 1000, 1'b0, S_RUN);
    chk (4'h9, 2000, 2000, 1'b0, S_RUN);

    // emergency stop drops everything at once, then a dead gap
    estop = 1'b1;
    chkn(2, 4'h0, 0, 0, 1'b0, S_FLT);
    estop = 1'b0;
    chkn(4, 4'h0, 0, 0, 1'b0, S_DEAD);
    chk (4'h9, 0, 0, 1'b0, S_RUN);
    chkn(2, 4'h9, 1000, 1000, 1'b0, S_RUN);
    chk (4'h9, 2000, 2000, 1'b0, S_RUN);

    // stop request: ramp to zero, then direction clears with no dead gap
    follow_dir = 4'h0;
    chk (4'h9, 2000, 2000, 1'b0, S_RUN);
    chkn(2, 4'h9, 1000, 1000, 1'b0, S_RUN);
    chk (4'h9, 0, 0, 1'b0, S_RUN);
    chk (4'h0, 0, 0, 1'b0, S_RUN);
    follow_dir = 4'h6;
    chkn(2, 4'h6, 0, 0, 1'b0, S_RUN);
    chk (4'h6, 1000, 1000, 1'b0, S_RUN);

    // reset in the middle of a dead interval; ramp counter restarts from zero
    estop = 1'b1;
    chk (4'h0, 0, 0, 1'b0, S_FLT);
    estop = 1'b0;
    chkn(2, 4'h0, 0, 0, 1'b0, S_DEAD);
    rst_n = 1'b0;
    chkn(2, 4'h0, 0, 0, 1'b0, S_RUN);
    rst_n = 1'b1;
    chk (4'h6, 0, 0, 1'b0, S_RUN);
    chkn(2, 4'h6, 1000, 1000, 1'b0, S_RUN);
    chk (4'h6, 2000, 2000, 1'b0, S_RUN);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/drive_arbiter.md
# drive_arbiter

Sequences and arbitrates the rover's single H-bridge/PWM drive resource between the line-follower command path, the IR/servo module, and an emergency stop. It sits between the line-following controller and the PWM/H-bridge outputs. It enforces duty-cycle ramping, a dead interval on every direction reversal, and a stopped-motor grant handshake before the servo module runs.

## Interface

Parameters:
- DEAD_CYCLES, 100000: cycles with Direction = 0 and zero duty required between opposite bridge directions.
- RAMP_STEP, 250: maximum duty change per channel per ramp tick.
- RAMP_DIV, 1000: clock cycles per ramp tick.

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- follow_dir  input  4  line-follower requested Direction; 0 = stop.
- follow_duty_a  input  12  line-follower requested DutyA.
- follow_duty_b  input  12  line-follower requested DutyB.
- servo_req  input  1  servo/IR module requests stopped motors (level).
- servo_grant  output  1  motors stopped; servo module may run.
- estop  input  1  emergency stop, highest priority (level).
- Direction  output  4  H-bridge direction to motor driver.
- DutyA  output  12  PWM duty, channel A.
- DutyB  output  12  PWM duty, channel B.
- arb_state  output  3  current state, for debug LEDs.

## Operation

- Priority: estop > servo_req > line follower.
- Ramp tick:
  - Free-running counter 0..RAMP_DIV-1; tick when the counter equals RAMP_DIV-1.
  - On a tick, each duty moves toward its target by min(RAMP_STEP, |target-current|), so it never overshoots.
  - Arithmetic is unsigned 12-bit. A step down saturates at 0; a step up is clamped to the target.
- States:
  - RUN (0):
    - Targets are follow_duty_a/b and Direction = follow_dir.
    - follow_dir == Direction: duties ramp to the targets.
    - follow_dir == 0: targets are forced to 0. Once both duties are 0, Direction <= 0 with no dead interval.
    - Direction == 0, both duties 0, follow_dir != 0: Direction <= follow_dir on the next edge, then ramp up.
    - follow_dir != Direction, both nonzero: go to RAMP_DOWN.
    - servo_req = 1: go to RAMP_DOWN with a servo flag set.
  - RAMP_DOWN (1):
    - Both duty targets are 0 and Direction holds.
    - If follow_dir returns to the current Direction before both duties reach 0 and no servo flag is set: back to RUN (abort), ramp up, no dead interval.
    - When both duties reach 0: Direction <= 0. Go to HOLD if the servo flag is set, otherwise go to DEAD.
  - DEAD (2):
    - Direction = 0 and duties = 0. Dead counter counts DEAD_CYCLES cycles, then go to RUN.
    - RUN loads follow_dir under the Direction == 0 rule.
  - HOLD (3):
    - servo_grant = 1, Direction = 0, duties = 0.
    - When servo_req falls: servo_grant <= 0, then DEAD.
  - FAULT (4):
    - Entered from any state when estop = 1. On the next edge Direction, DutyA, DutyB and servo_grant all go to 0, with no ramp.
    - Remain while estop = 1. When estop falls, go to DEAD.
- A servo_req that rises during DEAD or FAULT is honoured only after the block returns to RUN.
- servo_req dropping during RAMP_DOWN before the grant: clear the servo flag and follow the normal RAMP_DOWN rules.
- follow_* inputs are sampled every cycle and are not latched. The state always uses their current values.

## Timing

- All outputs are registered. An input change is reflected at the earliest on the next clk edge.
- Reset values:
  - Direction = 0, DutyA = DutyB = 0, servo_grant = 0.
  - arb_state = RUN (0).
  - Ramp and dead counters = 0.
- A synchronous reset mid-ramp or mid-dead forces all reset values on that edge. No ramp is applied.
- servo_grant rises exactly 1 cycle after the edge on which both duties reach 0 with Direction set to 0.
- Dead interval: Direction = 0 for exactly DEAD_CYCLES cycles before the new direction appears.
- Ramp-up latency from 0 to full target T: ceil(T/RAMP_STEP) ticks.

## Test plan

All scenarios use DEAD_CYCLES=4, RAMP_STEP=1000, RAMP_DIV=2.

- Reset, then follow_dir=0110 and duty 4000/4000 -> Direction=0110 on the next edge. Duties step 1000, 2000, 3000, 4000 every 2 cycles.
- At 4000 in 0110, change follow_dir to 1001 -> duties ramp 3000..0 over 4 ticks. Direction=0 for exactly 4 cycles, then 1001, then ramp up to 4000.
- Reversal request, then follow_dir returns to 0110 while duty=2000 -> RUN again, duty 3000, 4000. Direction is never 0.
- servo_req=1 while at 4000 -> ramp to 0 and Direction=0; servo_grant=1 one cycle later and held. Drop servo_req -> grant 0, 4 dead cycles, resume 0110 ramp.
- estop=1 while duty=2000 -> next edge all outputs 0, arb_state=4. Release -> 4 dead cycles, then RUN.
- rst_n=0 during DEAD with duty ramping in RUN afterwards -> next edge all outputs at reset values, arb_state=0.
